// File: rtl/mcu_pkg.sv
// Types and widths shared by the MCU datapath, the DMA loader and the RAM arbiter.
package mcu_pkg;

  localparam int unsigned MCU_ADDR_WIDTH = 12;
  localparam int unsigned MCU_DATA_WIDTH = 8;

  typedef enum logic {
    S_CPU_PRI = 1'b0,
    S_DMA_PRI = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating starvation counter: counts consecutive denied DMA cycles up to MAX_WAIT.
module arb_wait_counter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned WIDTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_WAIT);

  logic [WIDTH-1:0] r_count;

  // Clear wins over increment; the count holds once it reaches MAX_VAL.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != MAX_VAL)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/ram_bus_arbiter.sv
// Shares the single synchronous RAM port between the CPU datapath and the DMA/debug
// loader; CPU has default priority, a starvation counter hands DMA one guaranteed slot.
module ram_bus_arbiter
  import mcu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = MCU_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = MCU_DATA_WIDTH,
  parameter int unsigned MAX_WAIT       = 4,
  parameter int unsigned WAIT_CNT_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_rvalid,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  ram_write_enable,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  localparam logic [WAIT_CNT_WIDTH-1:0] LAST_WAIT = WAIT_CNT_WIDTH'(MAX_WAIT - 1);

  arb_state_t                r_state;
  arb_state_t                w_state_nxt;
  owner_t                    w_winner;
  owner_t                    w_rd_owner;
  owner_t                    r_rd_owner;
  logic                      w_cpu_gnt;
  logic                      w_dma_gnt;
  logic                      w_wait_inc;
  logic                      w_wait_clr;
  logic                      w_starved;
  logic [WAIT_CNT_WIDTH-1:0] w_wait_cnt;

  arb_wait_counter #(
    .MAX_WAIT (MAX_WAIT),
    .WIDTH    (WAIT_CNT_WIDTH)
  ) u_wait_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_wait_inc),
    .i_clear (w_wait_clr),
    .o_count (w_wait_cnt)
  );

  // Winner selection and next state; no grant can be issued while reset is high.
  always_comb begin
    w_state_nxt = r_state;
    w_winner    = OWN_NONE;

    if (!reset) begin
      case (r_state)
        S_CPU_PRI: begin
          if (cpu_req)      w_winner = OWN_CPU;
          else if (dma_req) w_winner = OWN_DMA;
        end
        S_DMA_PRI: begin
          if (dma_req)      w_winner = OWN_DMA;
          else if (cpu_req) w_winner = OWN_CPU;
        end
        default: w_winner = OWN_NONE;
      endcase
    end

    w_cpu_gnt  = (w_winner == OWN_CPU);
    w_dma_gnt  = (w_winner == OWN_DMA);
    w_wait_inc = dma_req && !w_dma_gnt;
    w_wait_clr = w_dma_gnt || !dma_req;
    // The denied cycle that brings the count to MAX_WAIT flips priority at its closing edge.
    w_starved  = w_wait_inc && (w_wait_cnt >= LAST_WAIT);

    case (r_state)
      S_CPU_PRI: if (w_starved)  w_state_nxt = S_DMA_PRI;
      S_DMA_PRI: if (w_wait_clr) w_state_nxt = S_CPU_PRI;
      default:                   w_state_nxt = S_CPU_PRI;
    endcase
  end

  // RAM port mux; idle bus drives zeros.
  always_comb begin
    ram_write_enable = 1'b0;
    ram_address      = '0;
    ram_data_in      = '0;
    case (w_winner)
      OWN_CPU: begin
        ram_write_enable = cpu_we;
        ram_address      = cpu_addr;
        ram_data_in      = cpu_wdata;
      end
      OWN_DMA: begin
        ram_write_enable = dma_we;
        ram_address      = dma_addr;
        ram_data_in      = dma_wdata;
      end
      default: begin
        ram_write_enable = 1'b0;
      end
    endcase
    w_rd_owner = (!ram_write_enable) ? w_winner : OWN_NONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_CPU_PRI;
      r_rd_owner <= OWN_NONE;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_owner <= w_rd_owner;
    end
  end

  assign cpu_gnt = w_cpu_gnt;
  assign dma_gnt = w_dma_gnt;

  // Read return steered to the recorded owner; a read still in flight when reset rises is dropped.
  assign cpu_rvalid = (r_rd_owner == OWN_CPU) && !reset;
  assign dma_rvalid = (r_rd_owner == OWN_DMA) && !reset;
  assign cpu_rdata  = cpu_rvalid ? ram_data_out : '0;
  assign dma_rdata  = dma_rvalid ? ram_data_out : '0;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Scenario bench for ram_bus_arbiter with a behavioural synchronous RAM and a read-return scoreboard.
module tb_ram_bus_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;

  typedef struct {
    int          due;
    bit          is_dma;
    logic [DW-1:0] data;
  } sb_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          dma_req = 1'b0, dma_we = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [DW-1:0] dma_wdata = '0;
  logic          cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, ram_write_enable;
  logic [DW-1:0] cpu_rdata, dma_rdata, ram_data_in;
  logic [DW-1:0] ram_data_out = '0;
  logic [AW-1:0] ram_address;

  logic [DW-1:0] ram_mem [0:4095];
  logic [DW-1:0] exp_mem [0:4095];
  sb_t           sb[$];
  int            cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;
  bit            mon_en = 1'b0;

  ram_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(4), .WAIT_CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .ram_write_enable(ram_write_enable), .ram_address(ram_address),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM: write at the edge, registered read data one cycle after the address.
  always @(posedge clk) begin
    if (ram_write_enable) ram_mem[ram_address] <= ram_data_in;
    ram_data_out <= ram_mem[ram_address];
  end

  // Read-return scoreboard: every cycle rvalid/rdata must match the queue head due this cycle.
  always @(negedge clk) begin
    bit            exp_c, exp_d;
    logic [DW-1:0] exp_data;
    if (mon_en) begin
      exp_c = 1'b0; exp_d = 1'b0; exp_data = '0;
      while (sb.size() > 0 && sb[0].due < cyc) begin
        n_vec++; n_err++;
        $display("FAIL sb_stale: read due cycle %0d never returned (now cycle %0d)", sb[0].due, cyc);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_c = !sb[0].is_dma;
        exp_d = sb[0].is_dma;
        exp_data = sb[0].data;
        void'(sb.pop_front());
      end
      n_vec++;
      if (cpu_rvalid !== exp_c || dma_rvalid !== exp_d) begin
        n_err++;
        $display("FAIL sb_rvalid cyc %0d: cpu_rvalid=%b dma_rvalid=%b, required %b/%b",
                 cyc, cpu_rvalid, dma_rvalid, exp_c, exp_d);
      end
      n_vec++;
      if (cpu_rdata !== (exp_c ? exp_data : 8'h00) || dma_rdata !== (exp_d ? exp_data : 8'h00)) begin
        n_err++;
        $display("FAIL sb_rdata cyc %0d: cpu_rdata=%h dma_rdata=%h, required %h/%h", cyc,
                 cpu_rdata, dma_rdata, exp_c ? exp_data : 8'h00, exp_d ? exp_data : 8'h00);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rd(input bit is_dma, input logic [AW-1:0] addr);
    sb.push_back('{due: cyc + 1, is_dma: is_dma, data: exp_mem[addr]});
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dma(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_cpu(1'b1, 1'b0, 12'h010, 8'h00);
    set_dma(1'b1, 1'b0, 12'h011, 8'h00);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      mon_en = 1'b1;
      n_vec++;
      if (cpu_gnt !== 1'b0 || dma_gnt !== 1'b0) begin
        n_err++;
        $display("FAIL reset_gnt: cpu_gnt=%b dma_gnt=%b, required 0/0", cpu_gnt, dma_gnt);
      end
      n_vec++;
      if (ram_write_enable !== 1'b0 || ram_address !== 12'h000 || ram_data_in !== 8'h00) begin
        n_err++;
        $display("FAIL reset_bus: we=%b addr=%h din=%h, required 0/000/00",
                 ram_write_enable, ram_address, ram_data_in);
      end
    end
    next_cycle();
    reset = 1'b0;
    push_rd(1'b0, 12'h010);
    @(negedge clk);
    n_vec++;
    if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0 || ram_address !== 12'h010) begin
      n_err++;
      $display("FAIL reset_first_gnt: cpu_gnt=%b dma_gnt=%b addr=%h, required 1/0/010",
               cpu_gnt, dma_gnt, ram_address);
    end
    next_cycle();
    set_cpu(1'b0, 1'b0, 12'h000, 8'h00);
    set_dma(1'b0, 1'b0, 12'h000, 8'h00);
  endtask

  task automatic test_cpu_write_read();
    next_cycle();
    set_cpu(1'b1, 1'b1, 12'h123, 8'hA5);
    exp_mem[12'h123] = 8'hA5;
    @(negedge clk);
    n_vec++;
    if (cpu_gnt !== 1'b1 || ram_write_enable !== 1'b1 || ram_address !== 12'h123 || ram_data_in !== 8'hA5) begin
      n_err++;
      $display("FAIL cpu_write: gnt=%b we=%b addr=%h din=%h, required 1/1/123/a5",
               cpu_gnt, ram_write_enable, ram_address, ram_data_in);
    end
    next_cycle();
    set_cpu(1'b1, 1'b0, 12'h123, 8'h00);
    push_rd(1'b0, 12'h123);
    @(negedge clk);
    n_vec++;
    if (cpu_gnt !== 1'b1 || ram_write_enable !== 1'b0) begin
      n_err++;
      $display("FAIL cpu_read_gnt: gnt=%b we=%b, required 1/0", cpu_gnt, ram_write_enable);
    end
    next_cycle();
    set_cpu(1'b0, 1'b0, 12'h000, 8'h00);
    @(negedge clk);
    n_vec++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'hA5 || dma_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL cpu_read_data: rvalid=%b rdata=%h dma_rvalid=%b, required 1/a5/0",
               cpu_rvalid, cpu_rdata, dma_rvalid);
    end
  endtask

  task automatic test_contention();
    bit d;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      set_cpu(1'b1, 1'b0, 12'h020, 8'h00);
      set_dma(1'b1, 1'b0, 12'h030, 8'h00);
      d = ((i % 5) == 4);
      push_rd(d, d ? 12'h030 : 12'h020);
      @(negedge clk);
      n_vec++;
      if (cpu_gnt !== !d || dma_gnt !== d) begin
        n_err++;
        $display("FAIL contention[%0d]: cpu_gnt=%b dma_gnt=%b, required %b/%b", i, cpu_gnt, dma_gnt, !d, d);
      end
      n_vec++;
      if (dut.w_wait_cnt !== 4'(i % 5)) begin
        n_err++;
        $display("FAIL contention_cnt[%0d]: wait_cnt=%0d, required %0d", i, dut.w_wait_cnt, i % 5);
      end
    end
    next_cycle();
    set_cpu(1'b0, 1'b0, 12'h000, 8'h00);
    set_dma(1'b0, 1'b0, 12'h000, 8'h00);
  endtask

  task automatic test_dma_alone();
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      set_dma(1'b1, 1'b0, 12'(i), 8'h00);
      push_rd(1'b1, 12'(i));
      @(negedge clk);
      n_vec++;
      if (dma_gnt !== 1'b1 || cpu_gnt !== 1'b0 || ram_address !== 12'(i)) begin
        n_err++;
        $display("FAIL dma_alone[%0d]: dma_gnt=%b cpu_gnt=%b addr=%h, required 1/0/%h",
                 i, dma_gnt, cpu_gnt, ram_address, 12'(i));
      end
    end
    next_cycle();
    set_dma(1'b0, 1'b0, 12'h000, 8'h00);
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    next_cycle();
    set_dma(1'b1, 1'b0, 12'h005, 8'h00);
    push_rd(1'b1, 12'h005);
    @(negedge clk);
    n_vec++;
    if (dma_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL midrd_gnt: dma_gnt=%b, required 1", dma_gnt);
    end
    next_cycle();
    reset = 1'b1;
    set_dma(1'b0, 1'b0, 12'h000, 8'h00);
    sb.delete();
    @(negedge clk);
    n_vec++;
    if (dma_rvalid !== 1'b0 || dma_rdata !== 8'h00) begin
      n_err++;
      $display("FAIL midrd_drop: dma_rvalid=%b dma_rdata=%h, required 0/00", dma_rvalid, dma_rdata);
    end
    next_cycle();
    reset = 1'b0;
    // Starve DMA into DMA priority, then reset and confirm CPU priority is restored.
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next_cycle();
      set_cpu(1'b1, 1'b0, 12'h040, 8'h00);
      set_dma(1'b1, 1'b0, 12'h050, 8'h00);
      push_rd(1'b0, 12'h040);
      @(negedge clk);
      n_vec++;
      if (cpu_gnt !== 1'b1) begin
        n_err++;
        $display("FAIL midrd_starve[%0d]: cpu_gnt=%b, required 1", i, cpu_gnt);
      end
    end
    next_cycle();
    reset = 1'b1;
    sb.delete();
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) next_cycle();
      push_rd(1'b0, 12'h040);
      @(negedge clk);
      n_vec++;
      if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0) begin
        n_err++;
        $display("FAIL post_reset_pri[%0d]: cpu_gnt=%b dma_gnt=%b, required 1/0", i, cpu_gnt, dma_gnt);
      end
    end
    next_cycle();
    set_cpu(1'b0, 1'b0, 12'h000, 8'h00);
    set_dma(1'b0, 1'b0, 12'h000, 8'h00);
  endtask

  task automatic test_dma_drop();
    bit d;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      set_cpu(1'b1, 1'b0, 12'h060, 8'h00);
      set_dma(1'b1, 1'b0, 12'h070, 8'h00);
      push_rd(1'b0, 12'h060);
      @(negedge clk);
      n_vec++;
      if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0) begin
        n_err++;
        $display("FAIL drop_pre[%0d]: cpu_gnt=%b dma_gnt=%b, required 1/0", i, cpu_gnt, dma_gnt);
      end
    end
    next_cycle();
    dma_req = 1'b0;
    push_rd(1'b0, 12'h060);
    @(negedge clk);
    n_vec++;
    if (dut.w_wait_cnt !== 4'd3) begin
      n_err++;
      $display("FAIL drop_cnt_before: wait_cnt=%0d, required 3", dut.w_wait_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      dma_req = 1'b1;
      d = (i == 4);
      push_rd(d, d ? 12'h070 : 12'h060);
      @(negedge clk);
      n_vec++;
      if (cpu_gnt !== !d || dma_gnt !== d || dut.w_wait_cnt !== 4'(i)) begin
        n_err++;
        $display("FAIL drop_after[%0d]: cpu_gnt=%b dma_gnt=%b wait_cnt=%0d, required %b/%b/%0d",
                 i, cpu_gnt, dma_gnt, dut.w_wait_cnt, !d, d, i);
      end
    end
    next_cycle();
    set_cpu(1'b0, 1'b0, 12'h000, 8'h00);
    set_dma(1'b0, 1'b0, 12'h000, 8'h00);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram_mem[i] = 8'((i * 7 + 3) ^ (i >> 8));
      exp_mem[i] = 8'((i * 7 + 3) ^ (i >> 8));
    end
    test_reset();
    test_cpu_write_read();
    test_contention();
    test_dma_alone();
    test_reset_mid_read();
    test_dma_drop();
    repeat (3) next_cycle();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d reads outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
